// File: rtl/ahb_periph_bridge.sv
// ---------------------------------------------------------------------------
// ahb_periph_bridge
//
// AHB-Lite slave front-end for a simple register peripheral. It turns the
// pipelined AHB address/data phases into single-cycle peripheral strobes
// (p_rd_en / p_wr_en). It also inserts wait states, rejects non-word or
// misaligned transfers, and drives the two-cycle AHB ERROR response.
//
// Optional feature (macro BRIDGE_RD_TIMEOUT_EN):
//   When the macro is defined, a read that stalls on p_ready=0 for
//   WAIT_TIMEOUT cycles is abandoned with an ERROR response. hrdata keeps
//   its previous value in that case.
//   When the macro is undefined, a read waits for p_ready indefinitely.
//
// Parameters
//   DATA_WIDTH    data bus width, both sides
//   ADDR_WIDTH    address width, both sides
//   WAIT_TIMEOUT  read stall limit (only with BRIDGE_RD_TIMEOUT_EN)
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active low
//   hsel       in   slave select
//   haddr      in   AHB address
//   htrans     in   transfer type (htrans[1]=1 : NONSEQ/SEQ)
//   hwrite     in   1 = write
//   hsize      in   transfer size, only word (3'b010) is legal
//   hwdata     in   write data (data phase)
//   hready     in   bus-wide ready
//   hreadyout  out  slave ready
//   hresp      out  0 = OKAY, 1 = ERROR
//   hrdata     out  registered read data
//   p_rd_en    out  peripheral read strobe
//   p_wr_en    out  peripheral write strobe
//   p_addr     out  registered transfer address
//   p_wr_data  out  write data while p_wr_en=1, else 0
//   p_rd_data  in   peripheral read data (combinational)
//   p_ready    in   peripheral read data valid
//   p_error    in   peripheral write error, valid the cycle after a write
// ---------------------------------------------------------------------------
module ahb_periph_bridge #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  p_rd_en,
  output logic                  p_wr_en,
  output logic [ADDR_WIDTH-1:0] p_addr,
  output logic [DATA_WIDTH-1:0] p_wr_data,
  input  logic [DATA_WIDTH-1:0] p_rd_data,
  input  logic                  p_ready,
  input  logic                  p_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DONE,
    S_WR,
    S_WR_CHK,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic [ADDR_WIDTH-1:0] p_addr_q;
  logic                  dir_q;

  logic   accept;
  logic   legal;
  logic   load;
  logic   ready_c;
  logic   resp_c;
  logic   rd_en_c;
  logic   wr_en_c;
  state_t next_xfer;

`ifdef BRIDGE_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  // The stall that would bring the count to WAIT_TIMEOUT is the last one.
  assign timeout = (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
`else
  localparam int unused_wait_timeout = WAIT_TIMEOUT;
`endif

  assign accept = hsel & hready & htrans[1];
  assign legal  = (hsize == 3'b010) && (haddr[1:0] == 2'b00);

  // Destination of an address phase seen while this slave is ready.
  always_comb begin
    next_xfer = S_IDLE;
    if (accept) begin
      if (!legal)      next_xfer = S_ERR1;
      else if (hwrite) next_xfer = S_WR;
      else             next_xfer = S_RD;
    end
  end

  always_comb begin
    state_d  = state_q;
    hrdata_d = hrdata_q;
    ready_c  = 1'b1;
    resp_c   = 1'b0;
    rd_en_c  = 1'b0;
    wr_en_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = next_xfer;
      end
      S_RD: begin
        rd_en_c = 1'b1;
        ready_c = 1'b0;
        if (p_ready) begin
          hrdata_d = p_rd_data;
          state_d  = S_RD_DONE;
        end
`ifdef BRIDGE_RD_TIMEOUT_EN
        else if (timeout) begin
          state_d = S_ERR1;
        end
`endif
      end
      S_RD_DONE: begin
        state_d = next_xfer;
      end
      S_WR: begin
        wr_en_c = 1'b1;
        ready_c = 1'b0;
        state_d = S_WR_CHK;
      end
      S_WR_CHK: begin
        // A flagged write turns this cycle into the first ERROR cycle.
        if (p_error) begin
          ready_c = 1'b0;
          resp_c  = 1'b1;
          state_d = S_ERR2;
        end else begin
          state_d = next_xfer;
        end
      end
      S_ERR1: begin
        ready_c = 1'b0;
        resp_c  = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        resp_c  = 1'b1;
        state_d = next_xfer;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A new address phase is only taken while this slave reports ready.
  assign load = accept & ready_c;

`ifdef BRIDGE_RD_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == S_RD) && (state_q != S_RD)) begin
      cnt_d = '0;
    end else if ((state_q == S_RD) && !p_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hrdata_q <= '0;
      p_addr_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hrdata_q <= hrdata_d;
      if (load) begin
        p_addr_q <= haddr;
        dir_q    <= hwrite;
      end
    end
  end

  // Qualifying with the captured direction keeps the two strobes exclusive.
  assign p_rd_en   = rd_en_c & ~dir_q;
  assign p_wr_en   = wr_en_c & dir_q;
  assign p_wr_data = p_wr_en ? hwdata : '0;
  assign hreadyout = ready_c;
  assign hresp     = resp_c;
  assign hrdata    = hrdata_q;
  assign p_addr    = p_addr_q;

endmodule

// File: tb/tb_ahb_periph_bridge.sv
module tb_ahb_periph_bridge;

  localparam int WT = 4;
`ifdef BRIDGE_RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        p_rd_en;
  logic        p_wr_en;
  logic [31:0] p_addr;
  logic [31:0] p_wr_data;
  logic [31:0] p_rd_data;
  logic        p_ready;
  logic        p_error;

  always #5 clk = ~clk;

  ahb_periph_bridge #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .WAIT_TIMEOUT(WT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hready   (hready),
    .hreadyout(hreadyout),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .p_rd_en  (p_rd_en),
    .p_wr_en  (p_wr_en),
    .p_addr   (p_addr),
    .p_wr_data(p_wr_data),
    .p_rd_data(p_rd_data),
    .p_ready  (p_ready),
    .p_error  (p_error)
  );

  // Single-slave system: the bus-wide ready is this slave's own ready.
  assign hready = hreadyout;

  // Peripheral register file (stimulus side).
  logic [31:0] pmem [16];
  assign p_rd_data = pmem[p_addr[5:2]];

  // Reference model state.
  logic [31:0] mmem [16];
  logic [31:0] last_rd;

  int checks = 0;
  int errors = 0;
  int cur_id = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    int          delay;
    logic        perr;
  } vec_t;

  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  typedef struct {
    int          waits;
    int          nrd;
    int          nwr;
    logic [1:0]  resp;
    logic        prev;
    logic [31:0] rdata;
    logic        done;
    logic        addr_ok;
    logic        wd_ok;
    logic        both;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %h expected %h", name, cur_id, act, exp);
    end
  endtask

  // Transaction-level behaviour derived from the bridge rules.
  task automatic model(input vec_t v, output exp_t e);
    int   idx;
    logic legal;
    idx   = int'(v.addr[5:2]);
    legal = (v.size == 3'b010) && (v.addr[1:0] == 2'b00);
    e.waits = 1; e.err = 1'b0; e.nrd = 0; e.nwr = 0;
    if (!legal) begin
      e.err = 1'b1;
    end else if (v.wr) begin
      e.nwr   = 1;
      e.err   = v.perr;
      e.waits = v.perr ? 2 : 1;
      mmem[idx] = v.wd;
    end else if (TO_EN && v.delay >= WT) begin
      e.nrd   = WT;
      e.waits = WT + 1;
      e.err   = 1'b1;
    end else begin
      e.nrd   = v.delay + 1;
      e.waits = v.delay + 1;
      last_rd = mmem[idx];
    end
    e.rdata = last_rd;
  endtask

  // Drives one address phase (from a point where the slave is ready) and
  // follows the data phase until hreadyout returns high. Returns at the
  // falling edge of the completion cycle so a following call is back-to-back.
  task automatic xfer(input vec_t v, output res_t r);
    r.waits = 0; r.nrd = 0; r.nwr = 0; r.resp = 2'b00; r.prev = 1'b0;
    r.rdata = '0; r.done = 1'b0; r.addr_ok = 1'b1; r.wd_ok = 1'b1; r.both = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hsize = v.size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = v.wd;
    for (int k = 0; k < 64; k++) begin
      p_ready = (k >= v.delay);
      p_error = (k == 1) ? v.perr : 1'b0;
      @(negedge clk);
      if (k == 0 && p_addr !== v.addr) r.addr_ok = 1'b0;
      if (p_rd_en && p_wr_en) r.both = 1'b1;
      if (p_rd_en) r.nrd++;
      if (p_wr_en) begin
        r.nwr++;
        if (p_wr_data !== v.wd) r.wd_ok = 1'b0;
        pmem[p_addr[5:2]] = p_wr_data;
      end else if (p_wr_data !== 32'h0) begin
        r.wd_ok = 1'b0;
      end
      if (hreadyout) begin
        r.done  = 1'b1;
        r.resp  = {r.prev, hresp};
        r.rdata = hrdata;
        break;
      end
      r.waits++;
      r.prev = hresp;
      @(posedge clk); #1;
    end
  endtask

  task automatic compare(input res_t r, input exp_t e);
    chk("done",   32'(r.done), 32'd1);
    chk("waits",  32'(r.waits), 32'(e.waits));
    chk("resp",   32'(r.resp), e.err ? 32'd3 : 32'd0);
    chk("hrdata", r.rdata, e.rdata);
    chk("n_rd",   32'(r.nrd), 32'(e.nrd));
    chk("n_wr",   32'(r.nwr), 32'(e.nwr));
    chk("p_addr", 32'(r.addr_ok), 32'd1);
    chk("wdata",  32'(r.wd_ok), 32'd1);
    chk("excl",   32'(r.both), 32'd0);
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = 2'b00; p_ready = 1'b0; p_error = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    chk({tag, "_hresp"},     32'(hresp), 32'd0);
    chk({tag, "_hrdata"},    hrdata, 32'd0);
    chk({tag, "_p_rd_en"},   32'(p_rd_en), 32'd0);
    chk({tag, "_p_wr_en"},   32'(p_wr_en), 32'd0);
    chk({tag, "_p_addr"},    p_addr, 32'd0);
  endtask

  rec_t tbl [10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    res_t r;

    rst = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; p_ready = 1'b0; p_error = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) begin
      pmem[i] = $urandom;
      mmem[i] = pmem[i];
    end

    //                  wr    addr          size    wd            dly perr   waits err rdata         nrd nwr
    tbl[0] = '{'{1'b1, 32'h4000_0004, 3'b010, 32'h0000_0064, 0, 1'b0}, '{1, 1'b0, 32'h0000_0000, 0, 1}};
    tbl[1] = '{'{1'b0, 32'h4000_0004, 3'b010, 32'h0000_0000, 0, 1'b0}, '{1, 1'b0, 32'h0000_0064, 1, 0}};
    tbl[2] = '{'{1'b1, 32'h4000_0020, 3'b010, 32'h0000_00A5, 0, 1'b1}, '{2, 1'b1, 32'h0000_0064, 0, 1}};
    tbl[3] = '{'{1'b0, 32'h4000_0000, 3'b000, 32'h0000_0000, 0, 1'b0}, '{1, 1'b1, 32'h0000_0064, 0, 0}};
    tbl[4] = '{'{1'b1, 32'h4000_0006, 3'b010, 32'h0000_0099, 0, 1'b0}, '{1, 1'b1, 32'h0000_0064, 0, 0}};
`ifdef BRIDGE_RD_TIMEOUT_EN
    tbl[5] = '{'{1'b0, 32'h4000_0004, 3'b010, 32'h0000_0000, 5, 1'b0}, '{5, 1'b1, 32'h0000_0064, 4, 0}};
`else
    tbl[5] = '{'{1'b0, 32'h4000_0004, 3'b010, 32'h0000_0000, 5, 1'b0}, '{6, 1'b0, 32'h0000_0064, 6, 0}};
`endif
    tbl[6] = '{'{1'b0, 32'h4000_0020, 3'b010, 32'h0000_0000, 2, 1'b0}, '{3, 1'b0, 32'h0000_00A5, 3, 0}};
    tbl[7] = '{'{1'b1, 32'h4000_0010, 3'b010, 32'h1234_5678, 0, 1'b0}, '{1, 1'b0, 32'h0000_00A5, 0, 1}};
    tbl[8] = '{'{1'b0, 32'h4000_0010, 3'b010, 32'h0000_0000, 0, 1'b0}, '{1, 1'b0, 32'h1234_5678, 1, 0}};
    tbl[9] = '{'{1'b1, 32'h4000_0014, 3'b010, 32'hDEAD_BEEF, 0, 1'b0}, '{1, 1'b0, 32'h1234_5678, 0, 1}};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_id = -1;
    chk_reset_vals("reset");
    chk("reset_p_wr_data", p_wr_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back.
    for (int i = 0; i < 10; i++) begin
      cur_id = i;
      model(tbl[i].v, e);
      xfer(tbl[i].v, r);
      compare(r, tbl[i].e);
    end

    // Non-transfers: BUSY, IDLE and deselected NONSEQ leave the slave idle.
    cur_id = 100;
    for (int i = 0; i < 3; i++) begin
      hsel   = (i < 2);
      htrans = (i == 0) ? 2'b01 : ((i == 1) ? 2'b00 : 2'b10);
      hwrite = 1'b1; hsize = 3'b010; haddr = 32'h4000_0008;
      @(posedge clk);
      @(negedge clk);
      chk("nontx_hreadyout", 32'(hreadyout), 32'd1);
      chk("nontx_hresp",     32'(hresp), 32'd0);
      chk("nontx_strobe",    32'(p_rd_en | p_wr_en), 32'd0);
    end

    // Reset asserted while the write strobe is active drops the transfer.
    cur_id = 101;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h4000_0008;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0077;
    chk("midrst_wr_active", 32'(p_wr_en), 32'd1);
    #1 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    last_rd = '0;
    @(negedge clk);
    cur_id = 102;
    v = '{1'b0, 32'h4000_0008, 3'b010, 32'h0, 1, 1'b0};
    model(v, e);
    xfer(v, r);
    compare(r, e);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cur_id    = 1000 + i;
      v.wr      = $urandom_range(0, 1);
      v.addr    = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.size    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      v.wd      = $urandom;
      v.delay   = $urandom_range(0, 5);
      v.perr    = ($urandom_range(0, 3) == 0);
      model(v, e);
      xfer(v, r);
      compare(r, e);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
